// File: rtl/data_sram_resp.sv
// ---------------------------------------------------------------------------
// data_sram_resp
//   Responder for the CPU data-side SRAM-style port. An access is sampled on
//   each rising edge, and read data appears on rdata one cycle later. Behind
//   the port are a byte-writable data RAM at physical address 0 and a small
//   confreg window with TIMER, LED, NUM and SWITCH registers.
//
// Parameters
//   MEM_AW     RAM word-address width. The RAM holds 4*2^MEM_AW bytes.
//   CONF_BASE  Base of the confreg window. Only bits [31:16] are decoded.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   en         access request
//   wen[3:0]   byte-lane write enables; 0 with en=1 means read
//   addr[31:0] physical byte address; bits [1:0] are ignored
//   wdata      write data
//   rdata      registered read data; holds until the next read or reset
//   switch     synchronised switch levels, read through SWITCH
//   led        LED register (16 bits)
//   num        seven-segment number register
// ---------------------------------------------------------------------------
module data_sram_resp #(
  parameter int unsigned MEM_AW    = 12,
  parameter logic [31:0] CONF_BASE = 32'h1faf_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam int unsigned RAM_WORDS = 1 << MEM_AW;

  // Confreg offsets, word-aligned.
  localparam logic [15:0] OFF_TIMER  = 16'he000;
  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_NUM    = 16'hf010;
  localparam logic [15:0] OFF_SWITCH = 16'hf020;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_TIMER,
    SEL_LED,
    SEL_NUM,
    SEL_SWITCH
  } sel_e;

  sel_e        sel;
  logic        rd_acc;
  logic        wr_acc;
  logic [31:0] lane_mask;
  logic [MEM_AW-1:0] ram_idx;

  logic [31:0] timer_d,   timer_q;
  logic [15:0] led_d,     led_q;
  logic [31:0] num_d,     num_q;
  logic [31:0] conf_rd_d, conf_rd_q;
  logic        src_ram_d, src_ram_q;
  logic [31:0] ram_rd_q;

  logic [31:0] mem [RAM_WORDS];

  // The byte offset bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // ---------------------------------------------------------------------
  // Address decode and access qualification.
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = SEL_NONE;
    if (addr[31:MEM_AW+2] == '0) begin
      sel = SEL_RAM;
    end else if (addr[31:16] == CONF_BASE[31:16]) begin
      unique case ({addr[15:2], 2'b00})
        OFF_TIMER:  sel = SEL_TIMER;
        OFF_LED:    sel = SEL_LED;
        OFF_NUM:    sel = SEL_NUM;
        OFF_SWITCH: sel = SEL_SWITCH;
        default:    sel = SEL_NONE;
      endcase
    end
  end

  // Accesses presented while rst is high are ignored entirely.
  assign rd_acc  = en && !rst && (wen == 4'b0000);
  assign wr_acc  = en && !rst && (wen != 4'b0000);
  assign ram_idx = addr[MEM_AW+1:2];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{wen[i]}};
    end
  end

  // ---------------------------------------------------------------------
  // Register next-state logic.
  // ---------------------------------------------------------------------
  always_comb begin
    timer_d   = timer_q + 32'd1;
    led_d     = led_q;
    num_d     = num_q;
    conf_rd_d = conf_rd_q;
    src_ram_d = src_ram_q;

    if (wr_acc) begin
      unique case (sel)
        // A TIMER write replaces the increment for this cycle; unselected
        // lanes keep the current (not incremented) value.
        SEL_TIMER: timer_d = (timer_q & ~lane_mask) | (wdata & lane_mask);
        SEL_LED:   led_d   = (led_q & ~lane_mask[15:0]) | (wdata[15:0] & lane_mask[15:0]);
        SEL_NUM:   num_d   = (num_q & ~lane_mask) | (wdata & lane_mask);
        default:   ;
      endcase
    end

    if (rd_acc) begin
      // RAM data comes from its own read register; everything else is
      // captured here. src_ram_q picks which one drives rdata.
      src_ram_d = (sel == SEL_RAM);
      unique case (sel)
        SEL_TIMER:  conf_rd_d = timer_q;
        SEL_LED:    conf_rd_d = {16'h0000, led_q};
        SEL_NUM:    conf_rd_d = num_q;
        SEL_SWITCH: conf_rd_d = {16'h0000, switch};
        default:    conf_rd_d = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      led_q     <= '0;
      num_q     <= '0;
      conf_rd_q <= '0;
      src_ram_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      led_q     <= led_d;
      num_q     <= num_d;
      conf_rd_q <= conf_rd_d;
      src_ram_q <= src_ram_d;
    end
  end

  // ---------------------------------------------------------------------
  // Data RAM: one port, byte-lane writes, registered read.
  // ---------------------------------------------------------------------
  // NOTE: the RAM array and its read register have no reset so they map
  // onto block RAM; rdata still reads 0 after reset because src_ram_q
  // clears and selects the reset conf_rd_q.
  always_ff @(posedge clk) begin
    if (wr_acc && sel == SEL_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) begin
          mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (rd_acc && sel == SEL_RAM) begin
      ram_rd_q <= mem[ram_idx];
    end
  end

  assign rdata = src_ram_q ? ram_rd_q : conf_rd_q;
  assign led   = led_q;
  assign num   = num_q;

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the CPU's data-side SRAM-style port: it receives `en/wen/addr/wdata` from the core and returns `rdata` one cycle later. It contains a byte-writable data RAM plus a small confreg window (LED, seven-segment number, switch readback, free-running timer). It sits directly below the CPU top, fed with already-translated physical addresses; the kseg0/kseg1 high-bit strip is done upstream.

## Interface
- `MEM_AW`, 12: RAM word-address width. RAM size is 4·2^MEM_AW bytes, at physical 0x0000_0000.
- `CONF_BASE`, 32'h1faf_0000: base of the confreg window. Only bits [31:16] are compared.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `en` in 1: access request, sampled each rising edge.
- `wen` in 4: byte-lane write enables. Bit i writes `wdata[8i+7:8i]`. 4'b0000 with `en` means read.
- `addr` in 32: physical byte address. Bits [1:0] are ignored.
- `wdata` in 32: write data.
- `rdata` out 32: registered read data.
- `switch` in 16: external switch levels, readable through the confreg window.
- `led` out 16: LED register.
- `num` out 32: seven-segment number register.

## Operation
- Decode, at the sampling edge, when `en`=1:
  - RAM hit: `addr < 4<<MEM_AW`. Word index is `addr[MEM_AW+1:2]`.
  - CONF hit: `addr[31:16] == CONF_BASE[31:16]`. Register selected by `addr[15:0]`:
    - 0xE000 TIMER: read/write.
    - 0xF000 LED: read/write, low 16 bits.
    - 0xF010 NUM: read/write.
    - 0xF020 SWITCH: read-only, zero-extended.
    - Any other offset reads 0; writes to it are dropped.
  - Neither window: writes dropped, reads return 0.
- Read (`en`=1, `wen`=0): `rdata` loads the selected word at the edge.
- Write (`wen`≠0):
  - Only enabled lanes of the target change.
  - `rdata` holds its previous value.
  - LED ignores lanes 2–3. SWITCH ignores all writes.
- `en`=0: nothing changes except TIMER; `rdata` holds.
- TIMER:
  - Increments by 1 every cycle not in reset, wrapping 0xFFFF_FFFF→0.
  - A write in the same cycle wins over the increment. Enabled lanes take `wdata`, the other lanes take the current value; no +1 that cycle.
  - The next cycle resumes counting from the written value.
  - A read returns the value before that edge's increment.
- RAM read-during-write is impossible: one port, and a write never updates `rdata`.

## Timing
- Read latency is exactly 1 cycle. Address at edge N gives data on `rdata` after edge N, held until the next accepted read or reset.
- Back-to-back reads every cycle are supported, with no stalls. There is no ready/valid signal: the core assumes every access completes.
- A write is visible to a read issued at the very next edge.
- Reset values, when `rst`=1 at an edge:
  - `rdata`=0, `led`=16'h0000, `num`=0, TIMER=0.
  - RAM contents are not reset.
  - Any access presented in a reset cycle is ignored, including writes.
- Reset mid-stream: the first access after `rst` falls is serviced normally. `rdata` shows 0 until that access.
- `switch` is sampled combinationally into the read mux at the edge; it is not synchronised here. The top level supplies synchronised levels.

## Test plan
- **Reset:** hold `rst` 3 cycles with `en`=1, `wen`=4'hF, `addr`=0xE000 window.
  - Required: `rdata`=0, `led`=0, `num`=0, TIMER=0.
  - Required: a read 5 cycles after release returns 5 ±0, exact per the increment rule.
- **Byte lanes:**
  - Write 0x1122_3344 to RAM 0x100 with `wen`=F, then 0xAABB_CCDD with `wen`=4'b0101.
  - Required: a read of 0x100 returns 0x11BB_33DD one cycle after its edge.
- **Back-to-back reads:** read 0x100, 0x104, 0x100 on consecutive edges.
  - Required: `rdata` sequence matches cycle-for-cycle with 1-cycle lag; `rdata` holds while `en`=0.
- **Confreg:**
  - Write 0xDEAD_BEEF to 0x1FAF_F000. Required: `led`=16'hBEEF.
  - Write 0x1234_5678 to 0x1FAF_F010. Required: `num`=0x1234_5678.
  - Set `switch`=16'hA5A5 and read 0x1FAF_F020. Required: 0x0000_A5A5.
  - Write SWITCH. Required: no effect.
- **Timer:**
  - Write 0xFFFF_FFFE to 0x1FAF_E000 with `wen`=F.
  - Required: reads on the next 3 consecutive edges return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 (wrap).
  - Partial write `wen`=4'b0001 of 0x55. Required: only the low byte is replaced, with no increment that cycle.
- **Unmapped:**
  - Read 0x2000_0000 and 0x1FAF_1234. Required: both return 0.
  - Write to them. Required: no RAM, LED, NUM or TIMER value changes.
